// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the pipeline and the RV32M multiply/divide unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             stall_req;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  busy, done, result, stall_req
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output busy, done, result, stall_req
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle over operand
// magnitudes, sign fix-up at the end, single-cycle fast path for divide by zero
// and signed overflow.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);
  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [DW-1:0]    acc_q;
  logic [WIDTH-1:0] opr_q;
  logic             neg_a_q;
  logic             neg_b_q;
  logic             busy_q;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] result_q;

  logic             in_div;
  logic             a_sgn;
  logic             b_sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             div_ovf;
  logic             fast;
  logic [WIDTH-1:0] fast_res;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_up;
  logic [WIDTH:0]   div_diff;
  logic [DW-1:0]    acc_step;
  logic [DW-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] fin_res;
  logic             done_c;

  // Decode the incoming request: signedness, magnitudes and fast-path cases.
  always_comb begin
    in_div   = bus.funct3[2];
    a_sgn    = in_div ? ~bus.funct3[0]
                      : (bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10);
    b_sgn    = in_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    a_neg    = a_sgn & bus.op_a[WIDTH-1];
    b_neg    = b_sgn & bus.op_b[WIDTH-1];
    a_mag    = a_neg ? (WIDTH'(0) - bus.op_a) : bus.op_a;
    b_mag    = b_neg ? (WIDTH'(0) - bus.op_b) : bus.op_b;
    div_zero = in_div && (bus.op_b == '0);
    div_ovf  = in_div && !bus.funct3[0]
               && (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}})
               && (bus.op_b == {WIDTH{1'b1}});
    fast     = div_zero || div_ovf;
    if (div_zero) begin
      fast_res = bus.funct3[1] ? bus.op_a : {WIDTH{1'b1}};
    end else begin
      fast_res = bus.funct3[1] ? '0 : bus.op_a;
    end
  end

  // One shift-add or restoring shift-subtract step, plus final sign fix-up.
  always_comb begin
    mul_sum  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opr_q} : '0);
    div_up   = acc_q[DW-1:WIDTH-1];
    div_diff = div_up - {1'b0, opr_q};
    if (op_q[2]) begin
      if (!div_diff[WIDTH]) begin
        acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {div_up[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod = (neg_a_q ^ neg_b_q) ? (DW'(0) - acc_step) : acc_step;
    quo  = (neg_a_q ^ neg_b_q) ? (WIDTH'(0) - acc_step[WIDTH-1:0]) : acc_step[WIDTH-1:0];
    rem  = neg_a_q ? (WIDTH'(0) - acc_step[DW-1:WIDTH]) : acc_step[DW-1:WIDTH];
    case (op_q)
      3'b000:                 fin_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[DW-1:WIDTH];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      fin_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q    <= bus.funct3;
            neg_a_q <= a_neg;
            neg_b_q <= b_neg;
            cnt_q   <= '0;
            if (fast) begin
              fin_q   <= fast_res;
              state_q <= S_DONE;
            end else begin
              acc_q   <= {WIDTH'(0), (in_div ? a_mag : b_mag)};
              opr_q   <= in_div ? b_mag : a_mag;
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              fin_q   <= fin_res;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!bus.flush) begin
            result_q <= fin_q;
          end
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // A flush in the done cycle suppresses both the pulse and the result update.
  assign done_c        = (state_q == S_DONE) && !bus.flush;
  assign bus.done      = done_c;
  assign bus.busy      = busy_q;
  assign bus.result    = done_c ? fin_q : result_q;
  assign bus.stall_req = rst && ((state_q == S_CALC)
                                 || ((state_q == S_IDLE) && bus.start && !bus.flush));
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, corner sequences and
// randomized operations against a plain-arithmetic reference model.
module tb_mul_div_unit;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end else begin
      passed++;
    end
  endtask

  // Reference result from ordinary 64-bit arithmetic on the RV32M definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f)
      3'd0, 3'd1: p = 64'(sa * sb);
      3'd2:       p = 64'(sa * ub);
      3'd3:       p = {32'b0, a} * {32'b0, b};
      3'd4:       p = (b == 0) ? 64'h0000_0000_FFFF_FFFF : 64'(sa / sb);
      3'd5:       p = (b == 0) ? 64'h0000_0000_FFFF_FFFF : {32'b0, a / b};
      3'd6:       p = (b == 0) ? {32'b0, a} : 64'(sa % sb);
      default:    p = (b == 0) ? {32'b0, a} : {32'b0, a % b};
    endcase
    return (f == 3'd1 || f == 3'd2 || f == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Entered and left just after a rising edge; lat counts cycles from acceptance to done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit stall_ok);
    bit seen;
    seen = 0; lat = -1; res = '0; stall_ok = 1;
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    if (!bus.stall_req) stall_ok = 0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom; bus.funct3 = 3'($urandom);
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1; lat = i; res = bus.result;
        if (bus.stall_req || bus.busy) stall_ok = 0;
      end else if (!bus.stall_req || !bus.busy) begin
        stall_ok = 0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic watch(input int n, output int dones, output int busys);
    dones = 0; busys = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.busy) busys++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] res, last_res, exp;
    int lat, dn, bz, sel;
    bit sok;
    logic [2:0] f;
    logic [31:0] a, b;
    passed = 0; total = 0;

    vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vt[1]  = '{3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
    vt[2]  = '{3'd3, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 33};
    vt[3]  = '{3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33};
    vt[4]  = '{3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33};
    vt[5]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    vt[6]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    vt[7]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vt[8]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vt[9]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vt[10] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    vt[11] = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vt[12] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33};
    vt[13] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    vt[14] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};

    // Reset values, with a request pending to show stall_req is gated by reset.
    rst = 1'b0; bus.start = 1'b1; bus.flush = 1'b0; bus.funct3 = 3'd0;
    bus.op_a = 32'd7; bus.op_b = 32'd3;
    @(negedge clk);
    chk("rst_busy",   32'(bus.busy),      32'd0);
    chk("rst_done",   32'(bus.done),      32'd0);
    chk("rst_result", bus.result,         32'd0);
    chk("rst_stall",  32'(bus.stall_req), 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed vectors; the first is accepted at the first edge out of reset.
    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].f, vt[i].a, vt[i].b, res, lat, sok);
      chk($sformatf("vec%0d_result", i), res, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
    end
    last_res = vt[NV-1].exp;

    // Flush a multiply while its counter is 10.
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd1234; bus.op_b = 32'd5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_calc_busy",   32'(bus.busy), 32'd0);
    chk("flush_calc_result", bus.result,    last_res);
    @(posedge clk); #1;
    watch(40, dn, bz);
    chk("flush_calc_no_done", 32'(dn), 32'd0);
    run_op(3'd0, 32'd1234, 32'd5678, res, lat, sok);
    chk("after_flush_result",  res,      32'd7006652);
    chk("after_flush_latency", 32'(lat), 32'd33);
    last_res = res;

    // Flush in the done cycle of a fast-path divide.
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd5; bus.op_b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_done_pulse",  32'(bus.done), 32'd0);
    chk("flush_done_result", bus.result,    last_res);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_done_held", bus.result, last_res);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a divide.
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_busy",   32'(bus.busy),      32'd0);
    chk("midrst_done",   32'(bus.done),      32'd0);
    chk("midrst_result", bus.result,         32'd0);
    chk("midrst_stall",  32'(bus.stall_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    watch(40, dn, bz);
    chk("midrst_no_done", 32'(dn), 32'd0);
    chk("midrst_no_busy", 32'(bz), 32'd0);

    // Start together with flush in IDLE is not accepted.
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd3;
    @(negedge clk);
    chk("startflush_stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    watch(40, dn, bz);
    chk("startflush_no_done", 32'(dn), 32'd0);
    chk("startflush_no_busy", 32'(bz), 32'd0);

    // Start held high during CALC is ignored: one done, original operands.
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(posedge clk); #1;
    bus.op_a = 32'd9; bus.op_b = 32'd9;
    dn = 0; res = '0;
    for (int i = 0; i < 40 && dn == 0; i++) begin
      @(negedge clk);
      if (bus.done) begin dn++; res = bus.result; end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("calc_start_result", res, 32'd15);
    watch(40, bz, lat);
    chk("calc_start_single_done", 32'(dn + bz), 32'd1);

    // Back-to-back DIV then MUL with stall_req tracked every cycle.
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, res, lat, sok);
    chk("b2b_div_result", res, 32'hFFFF_FFFA);
    chk("b2b_div_stall",  32'(sok), 32'd1);
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, sok);
    chk("b2b_mul_result", res, 32'hFFFF_FFEB);
    chk("b2b_mul_stall",  32'(sok), 32'd1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      exp = ref_res(f, a, b);
      run_op(f, a, b, res, lat, sok);
      chk($sformatf("rand%0d_f%0d_result", i, f), res, exp);
      chk($sformatf("rand%0d_f%0d_latency", i, f), 32'(lat), 32'(ref_lat(f, a, b)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous reset, active-low; rst=0 forces reset state immediately.
REQ-004 start  input  1  request a new RV32M operation, sampled in IDLE only.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  32  rs1 operand (forwarded ID/EX data1).
REQ-007 op_b  input  32  rs2 operand (forwarded ID/EX data2).
REQ-008 flush  input  1  abort any in-flight operation (branch/jump redirect).
REQ-009 busy  output  1  operation in progress (CALC state).
REQ-010 done  output  1  one-cycle pulse: result valid this cycle.
REQ-011 result  output  32  operation result; held after done until next accepted start.
REQ-012 stall_req  output  1  combinational; = (IDLE & start & ~flush) | CALC; holds PC, IF/ID and ID/EX.

Function
REQ-013 FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-014 IDLE: start=1 & flush=0 -> latch funct3, operands and sign info, counter=0, go to CALC; else stay.
REQ-015 CALC: one radix-2 iteration per cycle; counter increments 0..31; after iteration at counter=31 go to DONE.
REQ-016 DONE: done=1 for exactly one cycle, result driven, then IDLE unconditionally.
REQ-017 Normal latency: start accepted at edge N -> done high in cycle N+33 (32 CALC cycles + DONE); stall_req low in DONE cycle so the pipeline advances on the done cycle.
REQ-018 Multiply: shift-add over operand magnitudes into a 64-bit accumulator; sign fix-up after last iteration.
REQ-019 MUL returns product[31:0]; MULH, MULHSU, MULHU return product[63:32] with signed*signed, signed*unsigned, unsigned*unsigned semantics.
REQ-020 Divide: restoring shift-subtract over magnitudes; quotient negated if operand signs differ (signed ops); remainder takes dividend sign.
REQ-021 Divide by zero (op_b=0): DIV/DIVU -> 32'hFFFFFFFF, REM/REMU -> op_a; fast path IDLE->DONE, done at N+1, no CALC.
REQ-022 Signed overflow (DIV/REM with op_a=32'h80000000, op_b=32'hFFFFFFFF): DIV -> 32'h80000000, REM -> 0; same fast path.
REQ-023 start while in CALC or DONE is ignored; no queuing.
REQ-024 flush in CALC or DONE: next state IDLE, done not asserted (flush suppresses done in DONE cycle), result unchanged.
REQ-025 flush and start in same IDLE cycle: flush wins, nothing accepted, stall_req=0.
REQ-026 Operand inputs are not sampled after acceptance; changes during CALC have no effect.
REQ-027 All arithmetic modulo 2^32 / 2^64; no exceptions or flags raised.

Reset
REQ-028 rst=0: state IDLE, counter=0, busy=0, done=0, result=0, stall_req=0, internal accumulators=0.
REQ-029 rst asserted mid-CALC aborts operation; after release, no done pulse until a new start is accepted.
REQ-030 First start may be accepted at first rising edge with rst=1.

Verification
REQ-031 MUL op_a=7, op_b=-3 (32'hFFFFFFFD) -> done at N+33, result=32'hFFFFFFEB; MULH same operands -> 32'hFFFFFFFF; MULHU -> 32'h00000006.
REQ-032 DIV op_a=-20, op_b=3 -> result=32'hFFFFFFFA (-6); REM -> 32'hFFFFFFFE (-2); DIVU 100/7 -> 14; REMU -> 2.
REQ-033 DIVU op_b=0, op_a=5 -> done at N+1, result=32'hFFFFFFFF; REM op_a=5, op_b=0 -> 5; DIV 32'h80000000/-1 -> 32'h80000000 at N+1.
REQ-034 MUL start, flush at counter=10 -> IDLE next cycle, no done, busy=0, result keeps prior value; subsequent start completes normally.
REQ-035 rst pulsed low mid-CALC -> all outputs 0 immediately; start during CALC ignored (done only once per accepted start); start&flush in IDLE -> not accepted.
REQ-036 stall_req high from start cycle through last CALC cycle, low in DONE cycle; checked on back-to-back DIV then MUL.
